// File: rtl/audio_sched_pkg.sv
// Shared types and helpers for the audio clock scheduler.
package audio_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOCK = 2'd1,
        PRIME     = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int FRAME_CTR_W = 16;

    // ceil(log2(n)), never below 1 so counters always have at least one bit
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/clk_div_en.sv
// Generic modulo-N counter with enable and clear; wrap strobes on the last count.
module clk_div_en
    import audio_sched_pkg::*;
#(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int W = clog2(N);

    logic [W-1:0] cnt;

    assign wrap = en && (cnt == W'(N - 1));

    // modulo-N count register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= {W{1'b0}};
        end else if (clr) begin
            cnt <= {W{1'b0}};
        end else if (wrap) begin
            cnt <= {W{1'b0}};
        end else if (en) begin
            cnt <= cnt + W'(1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/audio_clock_scheduler.sv
// Codec clock generation, lock/prime sequencing and engine tick generation.
// Optional saturating drop counter enabled by AUDIO_SCHED_DROP_CNT_EN.
module audio_clock_scheduler
    import audio_sched_pkg::*;
#(
    parameter int MCLK_DIV     = 5,
    parameter int BCLK_DIV     = 2,
    parameter int FRAME_BITS   = 64,
    parameter int LOCK_FILTER  = 16,
    parameter int PRIME_FRAMES = 2
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   pll_lock,
    output logic                   mclk,
    output logic                   bclk,
    output logic                   lrclk,
    output logic                   codec_en,
    output logic                   dsp_reset,
    input  logic                   rx_valid,
    input  logic                   engine_ready,
    output logic                   tick_engine,
    output logic                   overrun,
    input  logic                   overrun_clr,
    output logic [FRAME_CTR_W-1:0] frame_count,
    output logic [15:0]            dropped_count
);

    localparam int BW = clog2(FRAME_BITS);
    localparam int LW = clog2(LOCK_FILTER);
    localparam int PW = clog2(PRIME_FRAMES);

    state_t         state;
    state_t         state_nxt;
    logic [LW-1:0]  lock_ctr;
    logic [BW-1:0]  bit_ctr;
    logic [BW-1:0]  bit_nxt;
    logic [PW-1:0]  prime_ctr;
    logic           rx_q;
    logic           rx_q2;
    logic           mclk_tick;
    logic           bclk_wrap;
    logic           active;
    logic           div_en;
    logic           bclk_fall;
    logic           frame_wrap;
    logic           lock_done;
    logic           prime_done;
    logic           in_run;
    logic           rx_rise;
    logic           accept;
    logic           drop;

    assign active     = (state == PRIME) || (state == RUN);
    assign div_en     = active && pll_lock;
    assign bclk_fall  = bclk_wrap && bclk;
    assign bit_nxt    = bit_ctr + BW'(1);
    assign frame_wrap = bclk_fall && (bit_ctr == {BW{1'b1}});
    assign lock_done  = (state == WAIT_LOCK) && pll_lock && (lock_ctr == LW'(LOCK_FILTER - 1));
    assign prime_done = (state == PRIME) && pll_lock && frame_wrap
                        && (prime_ctr == PW'(PRIME_FRAMES - 1));
    assign in_run     = (state == RUN) && pll_lock;
    assign rx_rise    = rx_q && !rx_q2;
    assign accept     = in_run && rx_rise && engine_ready;
    assign drop       = in_run && rx_rise && !engine_ready;

    clk_div_en #(.N(MCLK_DIV)) u_mclk_div (
        .clk   (sys_clk),
        .reset (reset),
        .en    (div_en),
        .clr   (!div_en),
        .wrap  (mclk_tick)
    );

    clk_div_en #(.N(BCLK_DIV)) u_bclk_div (
        .clk   (sys_clk),
        .reset (reset),
        .en    (mclk_tick),
        .clr   (!div_en),
        .wrap  (bclk_wrap)
    );

    // state register
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode; lock loss always returns to the lock filter
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_done) begin
                    state_nxt = PRIME;
                end else begin
                    state_nxt = WAIT_LOCK;
                end
            end
            PRIME: begin
                if (!pll_lock) begin
                    state_nxt = WAIT_LOCK;
                end else if (prime_done) begin
                    state_nxt = RUN;
                end else begin
                    state_nxt = PRIME;
                end
            end
            RUN: begin
                if (!pll_lock) begin
                    state_nxt = WAIT_LOCK;
                end else begin
                    state_nxt = RUN;
                end
            end
            default:   state_nxt = IDLE;
        endcase
    end

    // clock outputs, sequencing outputs and tick/overrun datapath
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            mclk        <= 1'b0;
            bclk        <= 1'b0;
            lrclk       <= 1'b0;
            codec_en    <= 1'b0;
            dsp_reset   <= 1'b1;
            tick_engine <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= {FRAME_CTR_W{1'b0}};
            lock_ctr    <= {LW{1'b0}};
            bit_ctr     <= {BW{1'b0}};
            prime_ctr   <= {PW{1'b0}};
            rx_q        <= 1'b0;
            rx_q2       <= 1'b0;
        end else begin
            rx_q        <= rx_valid;
            rx_q2       <= rx_q;
            tick_engine <= accept;
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end else begin
                overrun <= overrun;
            end
            if (div_en) begin
                codec_en <= 1'b1;
                lock_ctr <= {LW{1'b0}};
                if (mclk_tick) begin
                    mclk <= ~mclk;
                end
                if (bclk_wrap) begin
                    bclk <= ~bclk;
                end
                // lrclk follows the bit counter's next MSB so it moves with the bclk fall
                if (bclk_fall) begin
                    bit_ctr <= bit_nxt;
                    lrclk   <= bit_nxt[BW-1];
                end
                if (frame_wrap && (state == RUN)) begin
                    frame_count <= frame_count + FRAME_CTR_W'(1);
                end
                if (frame_wrap && (state == PRIME)) begin
                    prime_ctr <= prime_ctr + PW'(1);
                end
                if (prime_done) begin
                    dsp_reset <= 1'b0;
                end
            end else begin
                mclk        <= 1'b0;
                bclk        <= 1'b0;
                lrclk       <= 1'b0;
                bit_ctr     <= {BW{1'b0}};
                prime_ctr   <= {PW{1'b0}};
                frame_count <= {FRAME_CTR_W{1'b0}};
                dsp_reset   <= 1'b1;
                codec_en    <= lock_done;
                if ((state == WAIT_LOCK) && pll_lock && !lock_done) begin
                    lock_ctr <= lock_ctr + LW'(1);
                end else begin
                    lock_ctr <= {LW{1'b0}};
                end
            end
        end
    end

`ifdef AUDIO_SCHED_DROP_CNT_EN
    logic [15:0] drop_ctr;

    // saturating count of rejected samples; a drop coinciding with clear restarts at one
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            drop_ctr <= 16'd0;
        end else if (drop) begin
            if (overrun_clr) begin
                drop_ctr <= 16'd1;
            end else if (drop_ctr == 16'hFFFF) begin
                drop_ctr <= drop_ctr;
            end else begin
                drop_ctr <= drop_ctr + 16'd1;
            end
        end else if (overrun_clr) begin
            drop_ctr <= 16'd0;
        end else begin
            drop_ctr <= drop_ctr;
        end
    end

    assign dropped_count = drop_ctr;
`else
    assign dropped_count = 16'd0;
`endif

endmodule

// File: tb/tb_audio_clock_scheduler.sv
// Randomized bench for audio_clock_scheduler against a time-based behavioural model.
module tb_audio_clock_scheduler;

    localparam int MD      = 5;
    localparam int BD      = 2;
    localparam int FB      = 64;
    localparam int LF      = 16;
    localparam int PF      = 2;
    localparam int BCLK_T  = 2 * MD * BD;
    localparam int FRAME_T = BCLK_T * FB;
    localparam int RUN_T   = PF * FRAME_T;

    logic        sys_clk;
    logic        reset;
    logic        pll_lock;
    logic        mclk;
    logic        bclk;
    logic        lrclk;
    logic        codec_en;
    logic        dsp_reset;
    logic        rx_valid;
    logic        engine_ready;
    logic        tick_engine;
    logic        overrun;
    logic        overrun_clr;
    logic [15:0] frame_count;
    logic [15:0] dropped_count;

    int n_checks;
    int n_errors;

    // model: phase 0 idle, 1 waiting for lock, 2 clocks running (t cycles since start)
    int m_phase;
    int m_run;
    int m_t;
    bit m_rx1;
    bit m_rx2;
    bit m_ovr;
    bit m_tick;
    int m_drop;
    int hold;

    audio_clock_scheduler #(
        .MCLK_DIV     (MD),
        .BCLK_DIV     (BD),
        .FRAME_BITS   (FB),
        .LOCK_FILTER  (LF),
        .PRIME_FRAMES (PF)
    ) dut (
        .sys_clk       (sys_clk),
        .reset         (reset),
        .pll_lock      (pll_lock),
        .mclk          (mclk),
        .bclk          (bclk),
        .lrclk         (lrclk),
        .codec_en      (codec_en),
        .dsp_reset     (dsp_reset),
        .rx_valid      (rx_valid),
        .engine_ready  (engine_ready),
        .tick_engine   (tick_engine),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr),
        .frame_count   (frame_count),
        .dropped_count (dropped_count)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        bit in_run;
        bit rise;
        bit dr;
        if (reset) begin
            m_phase = 0; m_run = 0; m_t = 0;
            m_rx1 = 1'b0; m_rx2 = 1'b0; m_ovr = 1'b0; m_tick = 1'b0; m_drop = 0;
        end else begin
            in_run = (m_phase == 2) && (m_t >= RUN_T) && pll_lock;
            rise   = m_rx1 && !m_rx2;
            m_tick = in_run && rise && engine_ready;
            dr     = in_run && rise && !engine_ready;
            if (dr) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;
`ifdef AUDIO_SCHED_DROP_CNT_EN
            if (dr) m_drop = overrun_clr ? 1 : ((m_drop < 65535) ? m_drop + 1 : m_drop);
            else if (overrun_clr) m_drop = 0;
`endif
            m_rx2 = m_rx1;
            m_rx1 = rx_valid;
            case (m_phase)
                0: begin m_phase = 1; m_run = 0; end
                1: begin
                    if (pll_lock) begin
                        m_run = m_run + 1;
                        if (m_run == LF) begin m_phase = 2; m_t = 0; end
                    end else begin
                        m_run = 0;
                    end
                end
                default: begin
                    if (!pll_lock) begin m_phase = 1; m_run = 0; end
                    else m_t = m_t + 1;
                end
            endcase
        end
    endtask

    task automatic compare_all();
        bit         act;
        bit         in_run;
        logic [6:0] e;
        int         fc;
        act    = (m_phase == 2);
        in_run = act && (m_t >= RUN_T);
        e[6] = act && (((m_t / MD) % 2) == 1);
        e[5] = act && (((m_t / (MD * BD)) % 2) == 1);
        e[4] = act && (((m_t / BCLK_T) % FB) >= (FB / 2));
        e[3] = act;
        e[2] = !in_run;
        e[1] = m_tick;
        e[0] = m_ovr;
        fc = in_run ? (((m_t - RUN_T) / FRAME_T) % 65536) : 0;
        check("outs", {25'd0, mclk, bclk, lrclk, codec_en, dsp_reset, tick_engine, overrun},
              {25'd0, e});
        check("frame_count", {16'd0, frame_count}, fc);
        check("dropped_count", {16'd0, dropped_count}, m_drop);
    endtask

    task automatic cycle();
        @(posedge sys_clk);
        model_update();
        @(negedge sys_clk);
        compare_all();
    endtask

    task automatic traffic(input int n, input int p_ready);
        for (int i = 0; i < n; i++) begin
            if (hold == 0) begin
                rx_valid     = ~rx_valid;
                hold         = $urandom_range(1, 30);
                engine_ready = ($urandom_range(0, 99) < p_ready);
            end else begin
                hold = hold - 1;
            end
            overrun_clr = ($urandom_range(0, 49) == 0);
            cycle();
        end
        overrun_clr = 1'b0;
    endtask

    initial begin
        int cnt;
        int ticks;
        int first;
        n_checks = 0; n_errors = 0; hold = 0;
        reset = 1'b1; pll_lock = 1'b0; rx_valid = 1'b0; engine_ready = 1'b1; overrun_clr = 1'b0;
        @(negedge sys_clk);
        for (int i = 0; i < 3; i++) cycle();
        check("rst_dsp_reset", {31'd0, dsp_reset}, 32'd1);
        check("rst_clocks", {29'd0, mclk, codec_en, tick_engine}, 32'd0);

        // lock filter: 15 high, 1 low, then steady
        reset = 1'b0; pll_lock = 1'b1;
        for (int i = 0; i < 15; i++) cycle();
        pll_lock = 1'b0;
        cycle();
        pll_lock = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (codec_en && cnt == 0) cnt = i;
        end
        check("lock_latency", cnt, 32'd16 + 32'd24 - 32'd24);

        // prime: rx activity ignored, dsp_reset drops one prime interval after start
        cnt = 0;
        for (int i = 41; i <= 3000 && cnt == 0; i++) begin
            traffic(1, 50);
            if (!dsp_reset) cnt = i;
        end
        check("prime_len", cnt - 16, RUN_T);
        check("run_entry_frames", {16'd0, frame_count}, 32'd0);

        // single tick per rx_valid pulse
        rx_valid = 1'b0; engine_ready = 1'b1; overrun_clr = 1'b1;
        cycle();
        overrun_clr = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        for (int rep = 0; rep < 2; rep++) begin
            rx_valid = 1'b1; ticks = 0; first = 0;
            for (int i = 1; i <= 30; i++) begin
                cycle();
                if (tick_engine) begin
                    ticks = ticks + 1;
                    if (first == 0) first = i;
                end
            end
            check("tick_count", ticks, 32'd1);
            check("tick_latency", first, 32'd2);
            rx_valid = 1'b0;
            for (int i = 0; i < 70; i++) cycle();
        end

        // overrun, then clear colliding with the next drop
        engine_ready = 1'b0; rx_valid = 1'b1;
        cycle(); cycle();
        check("ovr_set", {31'd0, overrun}, 32'd1);
        rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        rx_valid = 1'b1;
        cycle();
        overrun_clr = 1'b1;
        cycle();
        overrun_clr = 1'b0;
        check("ovr_clr_collide", {31'd0, overrun}, 32'd1);
`ifdef AUDIO_SCHED_DROP_CNT_EN
        check("drop_clr_collide", {16'd0, dropped_count}, 32'd1);
`else
        check("drop_tied", {16'd0, dropped_count}, 32'd0);
`endif
        hold = 0;
        traffic(6000, 70);

        // lock loss in RUN
        pll_lock = 1'b0;
        cycle();
        pll_lock = 1'b1;
        check("loss_outs", {28'd0, mclk, bclk, codec_en, dsp_reset}, 32'd1);
        check("loss_frames", {16'd0, frame_count}, 32'd0);
        traffic(RUN_T + 40, 70);
        check("restart_run", {31'd0, dsp_reset}, 32'd0);

        // random lock glitches across all phases
        for (int k = 0; k < 12; k++) begin
            traffic($urandom_range(1, 3000), 60);
            pll_lock = 1'b0;
            traffic($urandom_range(1, 3), 60);
            pll_lock = 1'b1;
        end

        // reset mid-operation
        traffic(RUN_T + 40, 60);
        reset = 1'b1;
        traffic(1, 60);
        check("midrst_dsp_reset", {31'd0, dsp_reset}, 32'd1);
        reset = 1'b0;
        traffic(50, 60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/audio_clock_scheduler.md
Name: audio_clock_scheduler

Overview:
Owns codec clock generation and sample-tick sequencing between the I2S transceiver and the DSP engine.
- Divides sys_clk into mclk, bclk and lrclk.
- Filters PLL lock and sequences codec enable and DSP reset release.
- Converts the transceiver's rx_valid level into a single-cycle engine tick, gated by engine readiness, with overrun detection.
- Sits in the top level between the PLL, i2s_trx and dsp_engine_seq.

Parameters:
MCLK_DIV, 5, sys_clk cycles per mclk half-period (>=2)
BCLK_DIV, 2, mclk half-periods per bclk half-period (>=1)
FRAME_BITS, 64, bclk periods per lrclk frame (even, power of 2)
LOCK_FILTER, 16, consecutive pll_lock-high cycles required before start
PRIME_FRAMES, 2, full frames with dsp_reset held after clocks start

Ports:
sys_clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
pll_lock  in  1  raw PLL lock (already in sys_clk domain)
mclk  out  1  codec master clock
bclk  out  1  I2S bit clock
lrclk  out  1  I2S word select; high = second half of frame
codec_en  out  1  codec enable
dsp_reset  out  1  reset to i2s_trx and DSP engine
rx_valid  in  1  level from i2s_trx; high while a new sample is available
engine_ready  in  1  engine can accept a tick
tick_engine  out  1  one-cycle sample strobe to engine
overrun  out  1  sticky: a sample arrived while engine_ready was low
overrun_clr  in  1  clears overrun
frame_count  out  16  frames since entering RUN; wraps at 2^16
dropped_count  out  16  see Optional Feature

Behaviour:
- Reset values: all outputs 0, except dsp_reset=1. State is IDLE; all counters 0.
- States:
  - IDLE: unconditionally goes to WAIT_LOCK the next cycle.
  - WAIT_LOCK:
    - lock_ctr increments while pll_lock=1; any pll_lock=0 cycle clears it.
    - When lock_ctr reaches LOCK_FILTER-1 with pll_lock=1, go to PRIME and set codec_en=1.
    - Clocks are held low in this state.
  - PRIME:
    - Dividers run.
    - Go to RUN on the bclk falling edge that completes frame PRIME_FRAMES-1.
    - dsp_reset goes 0 in the same cycle as the transition.
  - RUN:
    - Dividers and tick logic are active.
  - Lock loss: pll_lock=0 in PRIME or RUN → WAIT_LOCK next cycle. In that cycle:
    - mclk, bclk, lrclk, codec_en and tick_engine are forced to 0 and dividers cleared.
    - dsp_reset=1 and frame_count is cleared.
    - overrun is kept.
- Dividers:
  - mclk_ctr counts 0..MCLK_DIV-1. At the wrap: mclk toggles and a one-cycle mclk_tick fires.
  - bclk_ctr counts mclk_ticks 0..BCLK_DIV-1 and bclk toggles at the wrap.
  - bit_ctr (log2 FRAME_BITS bits) increments on every bclk 1→0 toggle.
  - lrclk is registered from bit_ctr MSB, so lrclk changes only on bclk falling edges.
  - frame_count increments when bit_ctr wraps to 0, in RUN only.
  - With the defaults: mclk = sys_clk/10, bclk = mclk/2, lrclk = bclk/64.
- Tick logic (RUN only):
  - rx_valid is registered; the rising edge is detected from the registered copy.
  - On a rising edge with engine_ready=1: tick_engine=1 for exactly one cycle, 2 cycles after rx_valid rises.
  - On a rising edge with engine_ready=0: no tick, and overrun is set.
  - rx_valid held high never produces a second tick. It must fall and rise again.
  - Rising edges in PRIME and WAIT_LOCK are ignored and never set overrun.
- overrun_clr and a set event in the same cycle: set wins.
- Reset asserted mid-operation: returns all state to reset values on the next edge, overriding lock loss and ticks.

Optional Feature:
Macro AUDIO_SCHED_DROP_CNT_EN.
- Defined: dropped_count is a saturating 16-bit count (holds at 16'hFFFF) of rising edges rejected because engine_ready=0. It is cleared by reset and by overrun_clr; an increment in the same cycle as overrun_clr wins, giving 1.
- Undefined: dropped_count is tied to 0 and no counter is synthesised.

Decomposition:
Package audio_sched_pkg holds:
- state enum: IDLE, WAIT_LOCK, PRIME, RUN
- constant FRAME_CTR_W=16
- function clog2 used for bit_ctr and lock_ctr widths.

One sub-module, clk_div_en: a generic modulo-N counter with enable and clear, producing a wrap strobe. It is instantiated for the mclk and bclk stages.

Test Plan:
- Lock filter: pll_lock high 15 cycles, low 1, then high → codec_en rises exactly 16 cycles after the final rising edge; mclk stays low until then.
- Clock ratios: defaults, steady lock → mclk period 10 cycles, bclk period 20, lrclk period 1280; lrclk toggles only in cycles where bclk falls.
- Prime: dsp_reset deasserts on the bclk fall ending frame 1, i.e. 2560 cycles after clocks start (±divider phase); frame_count=0 at entry to RUN.
- Tick: rx_valid high 30 cycles with engine_ready=1 → exactly one tick_engine pulse, 2 cycles after rise; a second rx_valid rise 100 cycles later → a second pulse.
- Overrun: engine_ready=0 at the rx_valid rise → no tick, overrun=1, dropped_count=1 (macro on); overrun_clr in the same cycle as the next drop → overrun=1, dropped_count=1.
- Lock loss in RUN: pll_lock low 1 cycle → next cycle clocks=0, codec_en=0, dsp_reset=1, frame_count=0; with pll_lock restored, the start sequence repeats from WAIT_LOCK.
